// File: rtl/hough_video_pkg.sv
// Shared definitions for the Hough video pipeline: pixel/counter widths,
// source mode and FSM encodings, and the built-in test-pattern generator.
package hough_video_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_MEM   = 2'd0,
        MODE_HRAMP = 2'd1,
        MODE_VRAMP = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Test-pattern value for a raster position; memory mode yields 0 here
    // because its pixel comes from the frame memory instead.
    function automatic logic [PIX_W-1:0] pattern_pixel(
        input mode_e            mode,
        input logic [CNT_W-1:0] col,
        input logic [CNT_W-1:0] row
    );
        logic [PIX_W-1:0] pix;
        case (mode)
            MODE_HRAMP: pix = col;
            MODE_VRAMP: pix = row;
            MODE_CHECK: pix = (col[3] ^ row[3]) ? 8'hFF : 8'h00;
            default:    pix = '0;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row/linear-address raster counter with end-of-line, end-of-frame
// flags. load restarts at the origin; advance steps one pixel.
module raster_counter
    import hough_video_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [CNT_W-1:0]  line_len,
    input  logic [CNT_W-1:0]  num_lines,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row,
    output logic              last_pix
);

    // End-of-line / end-of-frame flags for the current position.
    always_comb begin
        last_col = (col == line_len - CNT_W'(1));
        last_row = (row == num_lines - CNT_W'(1));
        last_pix = last_col && last_row;
    end

    // Counters: load has priority so a frame wrap always restarts at 0.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (load) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
            addr <= last_pix ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/frame_source.sv
// Head of the pixel pipeline: rasters frames from a sync-read frame memory
// or a test pattern onto a gap-free pixel stream with line/frame markers.
// Pipeline: S0 counters/MemAddr/MemRd, S1 memory data or pattern, S2 outputs.
module frame_source
    import hough_video_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic              Continuous,
    input  logic [1:0]        Mode,
    input  logic [CNT_W-1:0]  LineLen,
    input  logic [CNT_W-1:0]  NumLines,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [PIX_W-1:0]  MemData,
    output logic [PIX_W-1:0]  PixelOut,
    output logic              LineOut,
    output logic              FrameOut,
    output logic              Busy
);

    state_e             state, state_nxt;
    logic               drain_cnt;
    logic               load, advance, latch;
    logic               params_ok, run;
    logic [CNT_W-1:0]   len_q, lines_q;
    mode_e              mode_q;

    logic [CNT_W-1:0]   col, row;
    logic [ADDR_W-1:0]  addr;
    logic               last_col, last_row, last_pix;

    logic               p1_valid, p1_line, p1_frame, p1_mem;
    logic [PIX_W-1:0]   p1_pat;
    logic               p2_line, p2_frame;
    logic [PIX_W-1:0]   p2_pix;

    raster_counter #(.ADDR_W(ADDR_W)) u_raster (
        .clk       (Clk),
        .rst_n     (nReset),
        .load      (load),
        .advance   (advance),
        .line_len  (len_q),
        .num_lines (lines_q),
        .col       (col),
        .row       (row),
        .addr      (addr),
        .last_col  (last_col),
        .last_row  (last_row),
        .last_pix  (last_pix)
    );

    assign params_ok = (LineLen != '0) && (NumLines != '0);
    assign run       = (state == ST_RUN);

    // Next-state and counter control; a wrap re-latches geometry and mode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        latch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Busy && params_ok) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                    latch     = 1'b1;
                end
            end
            ST_RUN: begin
                advance = 1'b1;
                if (last_pix) begin
                    if (Continuous && params_ok) begin
                        load  = 1'b1;
                        latch = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and two-cycle drain timer.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Frame parameters, captured at Start and at each wrap only.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            len_q   <= '0;
            lines_q <= '0;
            mode_q  <= MODE_MEM;
        end else if (latch) begin
            len_q   <= LineLen;
            lines_q <= NumLines;
            mode_q  <= mode_e'(Mode);
        end
    end

    // S0 memory interface; address forced to 0 when not rastering.
    always_comb begin
        MemAddr = run ? addr : '0;
        MemRd   = run && (mode_q == MODE_MEM);
    end

    // S1/S2 pipeline and registered outputs; markers travel with the pixel.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            p1_valid <= 1'b0;
            p1_line  <= 1'b0;
            p1_frame <= 1'b0;
            p1_mem   <= 1'b0;
            p1_pat   <= '0;
            p2_line  <= 1'b0;
            p2_frame <= 1'b0;
            p2_pix   <= '0;
            PixelOut <= '0;
            LineOut  <= 1'b0;
            FrameOut <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            p1_valid <= run;
            p1_line  <= run && last_col;
            p1_frame <= run && last_pix;
            p1_mem   <= (mode_q == MODE_MEM);
            p1_pat   <= pattern_pixel(mode_q, col, row);
            p2_line  <= p1_line;
            p2_frame <= p1_frame;
            p2_pix   <= p1_valid ? (p1_mem ? MemData : p1_pat) : '0;
            PixelOut <= p2_pix;
            LineOut  <= p2_line;
            FrameOut <= p2_frame;
            Busy     <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_frame_source.sv
// Scoreboard bench for frame_source: expected addresses and pixels are queued
// when a frame is requested and popped cycle by cycle as the DUT emits them.
module tb_frame_source;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        Start = 1'b0;
    logic        Continuous = 1'b0;
    logic [1:0]  Mode = 2'd0;
    logic [7:0]  LineLen = 8'd0;
    logic [7:0]  NumLines = 8'd0;
    logic [15:0] MemAddr;
    logic        MemRd;
    logic [7:0]  MemData = 8'd0;
    logic [7:0]  PixelOut;
    logic        LineOut;
    logic        FrameOut;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] pix;
        logic       line;
        logic       frame;
    } pix_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
    } addr_t;

    pix_t  pix_q[$];
    addr_t addr_q[$];
    logic [7:0] mem [0:65535];

    frame_source #(.ADDR_W(16)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Start      (Start),
        .Continuous (Continuous),
        .Mode       (Mode),
        .LineLen    (LineLen),
        .NumLines   (NumLines),
        .MemAddr    (MemAddr),
        .MemRd      (MemRd),
        .MemData    (MemData),
        .PixelOut   (PixelOut),
        .LineOut    (LineOut),
        .FrameOut   (FrameOut),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read frame memory model.
    always @(posedge Clk) if (MemRd) MemData <= mem[MemAddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference raster of one frame, written from the pixel definitions.
    task automatic push_frame(input int mode, input int len, input int lines);
        for (int r = 0; r < lines; r++) begin
            for (int c = 0; c < len; c++) begin
                int   a;
                pix_t p;
                addr_t e;
                a = r * len + c;
                case (mode)
                    0: p.pix = mem[a];
                    1: p.pix = 8'(c);
                    2: p.pix = 8'(r);
                    default: p.pix = (((c / 8) + (r / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                endcase
                p.line  = (c == len - 1);
                p.frame = (c == len - 1) && (r == lines - 1);
                e.addr  = 16'(a);
                e.rd    = (mode == 0);
                pix_q.push_back(p);
                addr_q.push_back(e);
            end
        end
    endtask

    // Pulse Start, then observe ncyc cycles comparing against the queues.
    // Cycle c is the cycle after the Start-sampling edge plus c clocks.
    task automatic run_window(input int ncyc, input int restart_at, input int drop_cont_at,
                              input int exp_width, output int busy_cnt, output int frame_cnt);
        int last_line_c;
        busy_cnt    = 0;
        frame_cnt   = 0;
        last_line_c = -1;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            Start = (c == restart_at);
            if (c == drop_cont_at) Continuous = 1'b0;
            if (Busy) busy_cnt++;
            if (FrameOut) frame_cnt++;
            if (addr_q.size() > 0) begin
                addr_t e;
                e = addr_q.pop_front();
                check("mem_rd", MemRd, e.rd);
                if (e.rd) check("mem_addr", MemAddr, e.addr);
            end else begin
                check("mem_rd_idle", MemRd, 1'b0);
            end
            if (c >= 3 && pix_q.size() > 0) begin
                pix_t p;
                p = pix_q.pop_front();
                check("pixel", PixelOut, p.pix);
                check("line_out", LineOut, p.line);
                check("frame_out", FrameOut, p.frame);
            end else begin
                check("idle_outputs", {PixelOut, LineOut, FrameOut}, 10'd0);
            end
            if (LineOut) begin
                if (last_line_c >= 0 && exp_width > 0)
                    check("line_width", c - last_line_c, exp_width);
                last_line_c = c;
            end
        end
        Start = 1'b0;
        check("pix_q_drained", pix_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        pix_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int busy_cnt, frame_cnt;
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];

        // Reset state.
        #12;
        check("reset_outputs", {MemAddr, MemRd, PixelOut, LineOut, FrameOut, Busy}, 28'd0);
        @(negedge Clk);
        nReset = 1'b1;

        // 1: 4x3 from memory, Start re-pulsed mid-frame.
        Mode = 2'd0; LineLen = 8'd4; NumLines = 8'd3; Continuous = 1'b0;
        push_frame(0, 4, 3);
        run_window(20, 5, -1, 4, busy_cnt, frame_cnt);
        check("t1_busy_cycles", busy_cnt, 14);
        check("t1_frame_pulses", frame_cnt, 1);

        // 2: continuous 3x2, three frames, then Continuous dropped.
        Mode = 2'd0; LineLen = 8'd3; NumLines = 8'd2; Continuous = 1'b1;
        push_frame(0, 3, 2);
        push_frame(0, 3, 2);
        push_frame(0, 3, 2);
        run_window(28, -1, 14, 3, busy_cnt, frame_cnt);
        check("t2_frame_pulses", frame_cnt, 3);
        check("t2_busy_cycles", busy_cnt, 20);

        // 3: checkerboard 32x16, memory untouched.
        Mode = 2'd3; LineLen = 8'd32; NumLines = 8'd16; Continuous = 1'b0;
        push_frame(3, 32, 16);
        run_window(520, -1, -1, 32, busy_cnt, frame_cnt);
        check("t3_frame_pulses", frame_cnt, 1);

        // Ramps, including a Mode change mid-frame that must not take effect.
        Mode = 2'd1; LineLen = 8'd5; NumLines = 8'd3;
        push_frame(1, 5, 3);
        fork
            begin repeat (4) @(negedge Clk); Mode = 2'd2; end
        join_none
        run_window(22, -1, -1, 5, busy_cnt, frame_cnt);
        Mode = 2'd2; LineLen = 8'd2; NumLines = 8'd4;
        push_frame(2, 2, 4);
        run_window(14, -1, -1, 2, busy_cnt, frame_cnt);

        // 4: single pixel, then illegal LineLen.
        Mode = 2'd0; LineLen = 8'd1; NumLines = 8'd1;
        push_frame(0, 1, 1);
        run_window(8, -1, -1, 0, busy_cnt, frame_cnt);
        check("t4_busy_cycles", busy_cnt, 3);
        check("t4_frame_pulses", frame_cnt, 1);
        LineLen = 8'd0; NumLines = 8'd4;
        run_window(8, -1, -1, 0, busy_cnt, frame_cnt);
        check("t4_len0_busy", busy_cnt, 0);

        // 5: reset mid-line, stay idle, then restart from address 0.
        LineLen = 8'd4; NumLines = 8'd3; Mode = 2'd0;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (5) @(negedge Clk);
        #2 nReset = 1'b0;
        #1 check("t5_reset_outputs", {MemAddr, MemRd, PixelOut, LineOut, FrameOut, Busy}, 28'd0);
        @(negedge Clk);
        nReset = 1'b1;
        repeat (4) @(negedge Clk);
        check("t5_idle_after_reset", {MemRd, PixelOut, LineOut, FrameOut, Busy}, 12'd0);
        push_frame(0, 4, 3);
        run_window(18, -1, -1, 4, busy_cnt, frame_cnt);
        check("t5_busy_cycles", busy_cnt, 14);

        // 6: long lines, width measured between consecutive LineOut pulses.
        Mode = 2'd1; LineLen = 8'd200; NumLines = 8'd3;
        push_frame(1, 200, 3);
        run_window(610, -1, -1, 200, busy_cnt, frame_cnt);
        check("t6_frame_pulses", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
